// File: rtl/m2vblkseq.sv
// m2vblkseq: MPEG-2 4:2:0 macroblock block sequencer.
// Walks Y0..Y3, Cb, Cr, framing each block for m2visdq and kicking the VLD for coded blocks.
module m2vblkseq #(
  parameter int NBLK = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       softreset,
  input  logic       mb_valid,
  output logic       mb_ready,
  input  logic [5:0] mb_cbp,
  input  logic       mb_intra,
  input  logic       mb_skip,
  input  logic [4:0] mb_qscode,
  input  logic       ready_isdq,
  output logic       s1_enable,
  output logic       s1_coded,
  output logic       s1_mb_intra,
  output logic [4:0] s1_mb_qscode,
  output logic [2:0] s1_blkidx,
  output logic       block_start,
  output logic       block_end,
  output logic       dec_start,
  input  logic       dec_eob,
  input  logic       dec_err,
  output logic       mb_done,
  output logic       err_flag
);

  localparam logic [2:0] LAST_IDX = 3'(NBLK - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_DEC, S_END} state_t;

  state_t     state_reg, state_next;
  logic [5:0] cbp_reg, cbp_next;
  logic [5:0] cbp_by_idx;
  logic       skip_reg, skip_next;
  logic       s1_enable_reg, s1_enable_next;
  logic       s1_coded_reg, s1_coded_next;
  logic       s1_mb_intra_reg, s1_mb_intra_next;
  logic [4:0] s1_mb_qscode_reg, s1_mb_qscode_next;
  logic [2:0] blkidx_reg, blkidx_next;
  logic       block_start_reg, block_start_next;
  logic       block_end_reg, block_end_next;
  logic       dec_start_reg, dec_start_next;
  logic       mb_done_reg, mb_done_next;
  logic       err_flag_reg, err_flag_next;
  logic       last_blk;
  logic       blk_finish;

  // cbp arrives MSB-first (bit5 = Y0); store it indexed by block number instead.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_cbp_rev
      assign cbp_by_idx[gi] = mb_cbp[5 - gi];
    end
  endgenerate

  assign last_blk = (blkidx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      cbp_reg          <= '0;
      skip_reg         <= 1'b0;
      s1_enable_reg    <= 1'b0;
      s1_coded_reg     <= 1'b0;
      s1_mb_intra_reg  <= 1'b0;
      s1_mb_qscode_reg <= '0;
      blkidx_reg       <= '0;
      block_start_reg  <= 1'b0;
      block_end_reg    <= 1'b0;
      dec_start_reg    <= 1'b0;
      mb_done_reg      <= 1'b0;
      err_flag_reg     <= 1'b0;
    end else if (softreset) begin
      state_reg        <= S_IDLE;
      cbp_reg          <= '0;
      skip_reg         <= 1'b0;
      s1_enable_reg    <= 1'b0;
      s1_coded_reg     <= 1'b0;
      s1_mb_intra_reg  <= 1'b0;
      s1_mb_qscode_reg <= '0;
      blkidx_reg       <= '0;
      block_start_reg  <= 1'b0;
      block_end_reg    <= 1'b0;
      dec_start_reg    <= 1'b0;
      mb_done_reg      <= 1'b0;
      err_flag_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cbp_reg          <= cbp_next;
      skip_reg         <= skip_next;
      s1_enable_reg    <= s1_enable_next;
      s1_coded_reg     <= s1_coded_next;
      s1_mb_intra_reg  <= s1_mb_intra_next;
      s1_mb_qscode_reg <= s1_mb_qscode_next;
      blkidx_reg       <= blkidx_next;
      block_start_reg  <= block_start_next;
      block_end_reg    <= block_end_next;
      dec_start_reg    <= dec_start_next;
      mb_done_reg      <= mb_done_next;
      err_flag_reg     <= err_flag_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cbp_next          = cbp_reg;
    skip_next         = skip_reg;
    s1_enable_next    = s1_enable_reg;
    s1_coded_next     = s1_coded_reg;
    s1_mb_intra_next  = s1_mb_intra_reg;
    s1_mb_qscode_next = s1_mb_qscode_reg;
    blkidx_next       = blkidx_reg;
    block_start_next  = 1'b0;
    block_end_next    = 1'b0;
    dec_start_next    = 1'b0;
    mb_done_next      = 1'b0;
    err_flag_next     = err_flag_reg;
    blk_finish        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (mb_valid) begin
          s1_mb_intra_next  = mb_intra;
          s1_mb_qscode_next = mb_qscode;
          skip_next         = mb_skip;
          if (mb_skip)
            cbp_next = 6'h00;
          else if (mb_intra)
            cbp_next = 6'h3F;
          else
            cbp_next = cbp_by_idx;
          err_flag_next = 1'b0;
          blkidx_next   = '0;
          state_next    = S_SETUP;
        end
      end
      S_SETUP: begin
        s1_enable_next = ~skip_reg;
        s1_coded_next  = cbp_reg[blkidx_reg];
        state_next     = S_WAIT;
      end
      S_WAIT: begin
        if (ready_isdq) begin
          block_start_next = 1'b1;
          dec_start_next   = s1_coded_reg;
          state_next       = S_DEC;
        end
      end
      S_DEC: begin
        // Uncoded blocks spend only the block_start cycle here so block_end never
        // coincides with block_start. VLD status is ignored during the dec_start cycle.
        if (!s1_coded_reg) begin
          blk_finish = 1'b1;
        end else if (!dec_start_reg && (dec_eob || dec_err)) begin
          blk_finish    = 1'b1;
          err_flag_next = err_flag_reg | dec_err;
        end
        if (blk_finish) begin
          block_end_next = 1'b1;
          mb_done_next   = last_blk;
          state_next     = S_END;
        end
      end
      S_END: begin
        if (last_blk) begin
          state_next = S_IDLE;
        end else begin
          blkidx_next = blkidx_reg + 3'd1;
          state_next  = S_SETUP;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mb_ready     = (state_reg == S_IDLE);
  assign s1_enable    = s1_enable_reg;
  assign s1_coded     = s1_coded_reg;
  assign s1_mb_intra  = s1_mb_intra_reg;
  assign s1_mb_qscode = s1_mb_qscode_reg;
  assign s1_blkidx    = blkidx_reg;
  assign block_start  = block_start_reg;
  assign block_end    = block_end_reg;
  assign dec_start    = dec_start_reg;
  assign mb_done      = mb_done_reg;
  assign err_flag     = err_flag_reg;

endmodule

// File: tb/tb_m2vblkseq.sv
// Self-checking bench for m2vblkseq: directed scenarios plus random macroblocks,
// with expected pulse timing derived from descriptor, ready_isdq and VLD responses.
module tb_m2vblkseq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       softreset = 1'b0;
  logic       mb_valid = 1'b0;
  logic       mb_ready;
  logic [5:0] mb_cbp = '0;
  logic       mb_intra = 1'b0;
  logic       mb_skip = 1'b0;
  logic [4:0] mb_qscode = '0;
  logic       ready_isdq = 1'b0;
  logic       s1_enable;
  logic       s1_coded;
  logic       s1_mb_intra;
  logic [4:0] s1_mb_qscode;
  logic [2:0] s1_blkidx;
  logic       block_start;
  logic       block_end;
  logic       dec_start;
  logic       dec_eob = 1'b0;
  logic       dec_err = 1'b0;
  logic       mb_done;
  logic       err_flag;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mb_count = 0;

  m2vblkseq #(.NBLK(6)) dut (
    .clk(clk), .reset_n(reset_n), .softreset(softreset),
    .mb_valid(mb_valid), .mb_ready(mb_ready), .mb_cbp(mb_cbp),
    .mb_intra(mb_intra), .mb_skip(mb_skip), .mb_qscode(mb_qscode),
    .ready_isdq(ready_isdq), .s1_enable(s1_enable), .s1_coded(s1_coded),
    .s1_mb_intra(s1_mb_intra), .s1_mb_qscode(s1_mb_qscode), .s1_blkidx(s1_blkidx),
    .block_start(block_start), .block_end(block_end), .dec_start(dec_start),
    .dec_eob(dec_eob), .dec_err(dec_err), .mb_done(mb_done), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // cyc seen at a negedge is the index of the rising edge just before it
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Runs one macroblock. Entered and left just after a falling edge.
  // hold_blk: ready_isdq forced low for 10 edges once that block could start.
  // err_blk: VLD answers with dec_err on that block. sr_blk: softreset during its DEC.
  task automatic run_mb(input logic [5:0] cbp, input logic intra, input logic skip,
                        input logic [4:0] qs, input int ready_pct, input int hold_blk,
                        input int err_blk, input int sr_blk);
    logic [5:0] eff;
    logic       coded;
    logic       err_acc;
    int acc, base, exp_start, exp_end, s_edge, e, delay, guard, done_edge;

    eff = skip ? 6'h00 : (intra ? 6'h3F : cbp);
    err_acc = 1'b0;
    done_edge = -1;

    chk("ready_idle", mb_ready, 1);
    mb_cbp = cbp; mb_intra = intra; mb_skip = skip; mb_qscode = qs; mb_valid = 1'b1;
    ready_isdq = 1'b0; dec_eob = 1'b0; dec_err = 1'b0;
    @(negedge clk);
    acc = cyc;
    mb_valid = 1'b0;
    mb_cbp = 6'($urandom); mb_intra = 1'($urandom); mb_skip = 1'($urandom);
    mb_qscode = 5'($urandom);
    chk("ready_busy", mb_ready, 0);
    chk("err_cleared", err_flag, 0);
    chk("qscode_latch", s1_mb_qscode, qs);
    chk("intra_latch", s1_mb_intra, intra);
    chk("idx_first", s1_blkidx, 0);
    base = acc + 2;

    for (int b = 0; b < 6; b++) begin
      coded = eff[5 - b];
      exp_start = -1;
      guard = 0;
      while (1) begin
        ready_isdq = ($urandom_range(0, 99) < ready_pct);
        if (b == hold_blk && cyc + 1 < base + 10) ready_isdq = 1'b0;
        dec_eob = ($urandom_range(0, 7) == 0);
        dec_err = 1'b0;
        if (exp_start < 0 && cyc + 1 >= base && ready_isdq) exp_start = cyc + 1;
        @(negedge clk);
        if (cyc >= base - 1) begin
          chk("wait_idx", s1_blkidx, b);
          chk("wait_enable", s1_enable, !skip);
          chk("wait_coded", s1_coded, coded);
        end
        if (exp_start >= 0 && cyc == exp_start) break;
        chk("no_start", block_start, 0);
        chk("no_end", block_end, 0);
        chk("no_dec_start", dec_start, 0);
        guard++;
        if (guard > 300) begin
          chk("start_timeout", 0, 1);
          return;
        end
      end
      s_edge = exp_start;
      chk("block_start", block_start, 1);
      chk("dec_start", dec_start, coded);
      chk("start_qscode", s1_mb_qscode, qs);
      chk("start_end_apart", block_end, 0);

      exp_end = coded ? -1 : s_edge + 1;
      delay = $urandom_range(2, 5);
      while (1) begin
        e = cyc + 1;
        dec_eob = 1'b0; dec_err = 1'b0; ready_isdq = 1'($urandom);
        if (coded && b == sr_blk && e == s_edge + 2) begin
          softreset = 1'b1;
          dec_eob = 1'b1;
        end else if (coded) begin
          if (e == s_edge + delay) begin
            if (b == err_blk) begin
              dec_err = 1'b1; dec_eob = 1'($urandom);
            end else begin
              dec_eob = 1'b1;
            end
          end else if (e == s_edge + 1) begin
            dec_eob = 1'($urandom);
            dec_err = 1'($urandom);
          end
          if (exp_end < 0 && e >= s_edge + 2 && (dec_eob || dec_err)) begin
            exp_end = e;
            err_acc = err_acc | dec_err;
          end
        end else begin
          dec_eob = 1'($urandom);
        end
        @(negedge clk);
        if (softreset) begin
          softreset = 1'b0; dec_eob = 1'b0; dec_err = 1'b0;
          chk("sr_ready", mb_ready, 1);
          chk("sr_no_end", block_end, 0);
          chk("sr_no_done", mb_done, 0);
          chk("sr_idx", s1_blkidx, 0);
          chk("sr_enable", s1_enable, 0);
          chk("sr_err", err_flag, 0);
          $display("mb %0d: cbp=%h intra=%0b skip=%0b qs=%0d aborted by softreset in block %0d",
                   mb_count, cbp, intra, skip, qs, b);
          mb_count++;
          return;
        end
        if (cyc == exp_end) break;
        chk("no_end_yet", block_end, 0);
        chk("no_done_yet", mb_done, 0);
        chk("busy", mb_ready, 0);
        if (cyc > s_edge + 20) begin
          chk("end_timeout", 0, 1);
          return;
        end
      end
      chk("block_end", block_end, 1);
      chk("end_no_start", block_start, 0);
      chk("mb_done", mb_done, (b == 5));
      chk("err_flag", err_flag, err_acc);
      chk("end_idx", s1_blkidx, b);
      chk("end_coded", s1_coded, coded);
      chk("end_enable", s1_enable, !skip);
      if (mb_done) done_edge = cyc;
      base = exp_end + 3;
    end
    dec_eob = 1'b0; dec_err = 1'b0; ready_isdq = 1'b0;
    @(negedge clk);
    chk("ready_after_done", mb_ready, 1);
    chk("done_one_cycle", mb_done, 0);
    if (eff == 6'h00 && ready_pct == 100 && hold_blk < 0)
      chk("uncoded_latency", done_edge - acc, 23);
    $display("mb %0d: cbp=%h intra=%0b skip=%0b qs=%0d eff=%h cycles=%0d err=%0b",
             mb_count, cbp, intra, skip, qs, eff, done_edge - acc, err_acc);
    mb_count++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", mb_ready, 1);
    chk("rst_enable", s1_enable, 0);
    chk("rst_coded", s1_coded, 0);
    chk("rst_intra", s1_mb_intra, 0);
    chk("rst_qscode", s1_mb_qscode, 0);
    chk("rst_idx", s1_blkidx, 0);
    chk("rst_pulses", {block_start, block_end, dec_start, mb_done}, 0);
    chk("rst_err", err_flag, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_mb(6'h00, 1'b1, 1'b0, 5'd5, 100, -1, -1, -1);     // intra, all coded
    run_mb(6'b100001, 1'b0, 1'b0, 5'd9, 100, -1, -1, -1); // Y0 and Cr coded
    run_mb(6'h2A, 1'b1, 1'b1, 5'd17, 100, -1, -1, -1);    // skip wins over intra
    run_mb(6'h15, 1'b0, 1'b0, 5'd3, 100, 2, -1, -1);      // isdq stalls block 2
    run_mb(6'h00, 1'b1, 1'b0, 5'd22, 100, -1, 1, -1);     // VLD error on block 1

    for (int i = 0; i < 6; i++) begin
      dec_eob = 1'b1;
      @(negedge clk);
      chk("idle_eob_no_end", block_end, 0);
      chk("idle_stays", mb_ready, 1);
      chk("err_sticky", err_flag, 1);
    end
    dec_eob = 1'b0;

    run_mb(6'h00, 1'b1, 1'b0, 5'd12, 100, -1, -1, 3);     // softreset in block 3
    run_mb(6'h3C, 1'b0, 1'b0, 5'd31, 70, -1, -1, -1);     // restarts from idx 0

    for (int i = 0; i < 14; i++) begin
      run_mb(6'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             5'($urandom), $urandom_range(30, 100), -1, $urandom_range(0, 7) - 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (edge %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
